muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the single-cycle ALU in the EX stage.
- Decode steers M-extension ops (opcode 0110011, funct7 0000001) here instead of ALUCU/ALU.
- Runs a shift-add / restoring-division datapath over multiple cycles and stalls the pipeline via a start/stall/done handshake.
- Produces one 32-bit result per accepted operation.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new op; sampled only in IDLE or DONE.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val  in  XLEN  dividend / multiplicand.
- rs2_val  in  XLEN  divisor / multiplier.
- flush  in  1  abort in-flight op (branch/flush from MEM).
- stall  out  1  combinational hold request to IF/ID/EX registers.
- busy  out  1  registered; high in CALC and FIX.
- done  out  1  registered one-cycle pulse; result valid.
- result  out  XLEN  registered; holds last completed value until the next done.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, busy=0, done=0, result=0, counter=0, internal operand/accumulator registers=0. Reset mid-operation discards the op with no done pulse.
- States and transitions:
  - IDLE: start=1 (and flush=0) latches operands and funct3. Special case -> DONE; otherwise -> CALC with counter=0.
  - CALC: one iteration per cycle. Leaves after XLEN iterations (counter reaches XLEN-1) -> FIX.
  - FIX: applies sign correction and selects the high/low product or quotient/remainder into result -> DONE.
  - DONE: done=1 for exactly this cycle. start=1 here is accepted like IDLE (back-to-back ops); otherwise -> IDLE.
- Latency: accept edge N; done=1 during the cycle after edge N+XLEN+2, i.e. 34 cycles for XLEN=32. Special cases: done the cycle after edge N+1.
- Operand preparation:
  - Signed ops take absolute values: MULH both operands, MULHSU rs1 only, DIV/REM both.
  - Result sign flags are latched at accept.
- Multiply: 2*XLEN-bit accumulator, shift-add on the LSB of the multiplier.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
  - Negation is applied to the full 2*XLEN product before the high/low select.
- Divide: restoring, one quotient bit per cycle, remainder width XLEN+1 for the trial subtract.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- Special cases, resolved at accept with no CALC:
  - Divisor=0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (rs1=0x8000_0000, rs2=0xFFFF_FFFF): DIV -> 0x8000_0000; REM -> 0.
- stall = start & (state is IDLE or DONE) & ~flush, OR busy. Consequences:
  - Issuing stage is held from the start cycle through FIX.
  - stall=0 in the DONE cycle, so EX captures result while done=1.
- flush has priority over start and over all states: next state IDLE, no done, result unchanged.
- Simultaneous rst and flush: rst wins (result cleared).
- Operands, funct3 and start changing while busy are ignored.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: for multiply ops, CALC exits to FIX as soon as the remaining multiplier shift register is zero, which also covers rs2=0. Minimum multiply latency is 3 cycles; division timing is unchanged.
- Undefined: CALC always runs exactly XLEN iterations; latency is fixed at XLEN+2 for all non-special ops.

Decomposition:
- Package muldiv_pkg holds:
  - funct3 localparams (F3_MUL .. F3_REMU);
  - state encoding (S_IDLE, S_CALC, S_FIX, S_DONE, 2 bits);
  - the DIV_ZERO_Q and OVF_Q constants.
- One sub-module is natural: muldiv_sign_fix.
  - Combinational conditional two's-complement negate for 2*XLEN and XLEN values.
  - Reused for operand absolute values and FIX-stage correction.
- Controller FSM, counter and iterative datapath stay in muldiv_seq.

Test Plan:
- MUL 7 x -3 (0x7, 0xFFFF_FFFD) -> done at cycle 34 after accept, result 0xFFFF_FFEB; stall high cycles 0-33, low in the done cycle.
- MULH / MULHSU / MULHU with 0x8000_0000 x 0xFFFF_FFFF -> 0x0000_0000 / 0x8000_0000 / 0x7FFF_FFFF.
- DIV -20 / 3 -> 0xFFFF_FFFA; REM -20 / 3 -> 0xFFFF_FFFE; DIVU 20 / 3 -> 6.
- DIV x / 0 with x=0x1234 -> 0xFFFF_FFFF; REMU 0x1234 / 0 -> 0x1234; DIV 0x8000_0000 / -1 -> 0x8000_0000. Each has done the cycle after accept.
- flush asserted at CALC iteration 10 -> IDLE next cycle, no done, result keeps prior value; a new start on the same cycle as flush is ignored.
- Back-to-back: start held high in the DONE cycle with MULHU 0xFFFF_FFFF x 2 -> second done 34 cycles later, result 0x1. With MULDIV_EARLY_OUT_EN, MUL 5 x 1 -> done 3 cycles after accept, result 5.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q      = 32'h8000_0000;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and final sign correction.
module muldiv_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer with start/stall/done handshake.
// Optional macro MULDIV_EARLY_OUT_EN: multiplies leave CALC once the multiplier is exhausted.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned W2 = 2 * XLEN;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3;
  logic             neg_res;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    opa;
  logic [XLEN-1:0]  opb;

  // Accept-time decode
  logic            rs1_signed, rs2_signed, a_neg, b_neg, neg_in;
  logic            div_zero, ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, special_res;
  logic [W2-1:0]   opa_init;
  logic [XLEN-1:0] opb_init;

  assign rs1_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign rs2_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign a_neg      = rs1_signed & rs1_val[XLEN-1];
  assign b_neg      = rs2_signed & rs2_val[XLEN-1];
  // Remainder follows the dividend; everything else follows the sign product.
  assign neg_in     = (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);

  muldiv_sign_fix #(.W(XLEN)) u_abs_a (.neg(a_neg), .din(rs1_val), .dout(abs_a));
  muldiv_sign_fix #(.W(XLEN)) u_abs_b (.neg(b_neg), .din(rs2_val), .dout(abs_b));

  assign div_zero = funct3[2] && (rs2_val == '0);
  assign ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (rs1_val == OVF_Q) && (rs2_val == '1);
  assign special  = div_zero | ovf;

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? rs1_val : DIV_ZERO_Q;
    end else if (!funct3[1]) begin
      special_res = OVF_Q;
    end
  end

  // Divide keeps the divisor in opa and the dividend/quotient in opb.
  assign opa_init = funct3[2] ? {{XLEN{1'b0}}, abs_b} : {{XLEN{1'b0}}, abs_a};
  assign opb_init = funct3[2] ? abs_a : abs_b;

  // One iteration of the datapath
  logic [W2-1:0]   acc_nxt, opa_nxt;
  logic [XLEN-1:0] opb_nxt;
  logic [XLEN:0]   rem_sh, trial;
  logic            calc_last;

  always_comb begin
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    rem_sh  = {acc[XLEN-1:0], opb[XLEN-1]};
    trial   = rem_sh - {1'b0, opa[XLEN-1:0]};
    if (f3[2]) begin
      acc_nxt = {{(XLEN-1){1'b0}}, (trial[XLEN] ? rem_sh : trial)};
      opb_nxt = {opb[XLEN-2:0], ~trial[XLEN]};
    end else begin
      acc_nxt = acc + (opb[0] ? opa : '0);
      opa_nxt = opa << 1;
      opb_nxt = opb >> 1;
    end
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign calc_last = (cnt == CNT_W'(XLEN - 1)) || (!f3[2] && (opb_nxt == '0));
`else
  assign calc_last = (cnt == CNT_W'(XLEN - 1));
`endif

  // Final sign correction and selection
  logic [W2-1:0]   prod_fix;
  logic [XLEN-1:0] div_sel, div_fix, fix_res;

  assign div_sel = f3[1] ? acc[XLEN-1:0] : opb;

  muldiv_sign_fix #(.W(W2))   u_fix_prod (.neg(neg_res), .din(acc),     .dout(prod_fix));
  muldiv_sign_fix #(.W(XLEN)) u_fix_div  (.neg(neg_res), .din(div_sel), .dout(div_fix));

  assign fix_res = f3[2]            ? div_fix :
                   (f3 == F3_MUL)   ? prod_fix[XLEN-1:0] : prod_fix[W2-1:XLEN];

  assign stall = (start & ((state == S_IDLE) | (state == S_DONE)) & ~flush) | busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cnt     <= '0;
      f3      <= '0;
      neg_res <= 1'b0;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            f3      <= funct3;
            neg_res <= neg_in;
            cnt     <= '0;
            acc     <= '0;
            opa     <= opa_init;
            opb     <= opb_init;
            if (special) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_CALC;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          opa <= opa_nxt;
          opb <= opb_nxt;
          cnt <= cnt + CNT_W'(1);
          if (calc_last) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result <= fix_res;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk, rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic        stall, busy, done;
  logic [31:0] result;

  int tests_run    = 0;
  int tests_failed = 0;

  muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1_val(rs1_val),
    .rs2_val(rs2_val),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Issue one op and return the cycle (start cycle = 0) in which done was seen.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res);
    lat = -1;
    res = 'x;
    @(negedge clk);
    funct3 = f; rs1_val = a; rs2_val = b; start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        res = result;
        break;
      end
      start   = 1'b0;
      rs1_val = $urandom;
      rs2_val = $urandom;
      funct3  = 3'($urandom_range(0, 7));
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, stall} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 000", {busy, done, stall});
    end
    tests_run++;
    if (result !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_result: got %h expected 00000000", result);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %b expected 00", {busy, done});
    end
  endtask

  task automatic test_mul;
    int stall_bad = 0;
    int lat = -1;
    logic [31:0] res = 'x;
    logic stall_done = 1'bx;
    @(negedge clk);
    funct3 = F3_MUL; rs1_val = 32'h7; rs2_val = 32'hFFFF_FFFD; start = 1'b1;
    #1;
    if (stall !== 1'b1) stall_bad++;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c; res = result; stall_done = stall;
        break;
      end
      if (stall !== 1'b1) stall_bad++;
      start = 1'b0;
      rs1_val = $urandom;
    end
    start = 1'b0;
    tests_run++;
    if (lat !== 34) begin
      tests_failed++;
      $display("FAIL mul_latency: got %0d expected 34", lat);
    end
    tests_run++;
    if (res !== 32'hFFFF_FFEB) begin
      tests_failed++;
      $display("FAIL mul_result: got %h expected ffffffeb", res);
    end
    tests_run++;
    if (stall_bad !== 0) begin
      tests_failed++;
      $display("FAIL mul_stall_busy: got %0d low cycles expected 0", stall_bad);
    end
    tests_run++;
    if (stall_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_stall_done: got %b expected 0", stall_done);
    end
  endtask

  task automatic test_mulh;
    logic [2:0]  f  [3] = '{F3_MULH, F3_MULHSU, F3_MULHU};
    logic [31:0] ex [3] = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF};
`ifdef MULDIV_EARLY_OUT_EN
    int exl [3] = '{3, 34, 34};
`else
    int exl [3] = '{34, 34, 34};
`endif
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 3; i++) begin
      run_op(f[i], 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
      tests_run++;
      if (res !== ex[i]) begin
        tests_failed++;
        $display("FAIL mulh_result[%0d]: got %h expected %h", i, res, ex[i]);
      end
      tests_run++;
      if (lat !== exl[i]) begin
        tests_failed++;
        $display("FAIL mulh_latency[%0d]: got %0d expected %0d", i, lat, exl[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  f  [6] = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIV, F3_REM};
    logic [31:0] a  [6] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20, 32'd20, 32'd20};
    logic [31:0] b  [6] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    logic [31:0] ex [6] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd6, 32'd2, 32'hFFFF_FFFA, 32'd2};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 6; i++) begin
      run_op(f[i], a[i], b[i], lat, res);
      tests_run++;
      if (res !== ex[i] || lat !== 34) begin
        tests_failed++;
        $display("FAIL div[%0d]: got %h lat %0d expected %h lat 34", i, res, lat, ex[i]);
      end
    end
  endtask

  task automatic test_special;
    logic [2:0]  f  [5] = '{F3_DIV, F3_REM, F3_DIV, F3_REM, F3_REMU};
    logic [31:0] a  [5] = '{32'h1234, 32'h5678, 32'h8000_0000, 32'h8000_0000, 32'h1234};
    logic [31:0] b  [5] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] ex [5] = '{32'hFFFF_FFFF, 32'h5678, 32'h8000_0000, 32'h0, 32'h1234};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 5; i++) begin
      run_op(f[i], a[i], b[i], lat, res);
      tests_run++;
      if (res !== ex[i] || lat !== 1) begin
        tests_failed++;
        $display("FAIL special[%0d]: got %h lat %0d expected %h lat 1", i, res, lat, ex[i]);
      end
    end
  endtask

  task automatic test_flush;
    int lat;
    logic [31:0] res;
    bit seen_done = 1'b0;
    run_op(F3_DIVU, 32'd20, 32'd3, lat, res);
    tests_run++;
    if (res !== 32'd6) begin
      tests_failed++;
      $display("FAIL flush_setup: got %h expected 00000006", res);
    end
    @(negedge clk);
    funct3 = F3_MUL; rs1_val = 32'h7; rs2_val = 32'hFFFF_FFFD; start = 1'b1;
    repeat (11) begin
      @(negedge clk);
      start = 1'b0;
    end
    // Iteration 10 is in progress; a colliding start must be dropped.
    funct3 = F3_DIV; rs1_val = 32'h1234; rs2_val = 32'h0; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy, done} !== 2'b00 || result !== 32'd6) begin
      tests_failed++;
      $display("FAIL flush_calc: got busy/done %b result %h expected 00 00000006",
               {busy, done}, result);
    end
    start = 1'b0; flush = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    tests_run++;
    if (seen_done !== 1'b0 || result !== 32'd6) begin
      tests_failed++;
      $display("FAIL flush_no_done: got done %b result %h expected 0 00000006", seen_done, result);
    end
    funct3 = F3_DIV; rs1_val = 32'h1234; rs2_val = 32'h0; start = 1'b1; flush = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle_stall: got %b expected 0", stall);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    tests_run++;
    if ({busy, done} !== 2'b00 || result !== 32'd6) begin
      tests_failed++;
      $display("FAIL flush_idle_start: got busy/done %b result %h expected 00 00000006",
               {busy, done}, result);
    end
  endtask

  task automatic test_back_to_back;
    int lat1 = -1;
    int lat2 = -1;
    logic [31:0] res1 = 'x;
    logic [31:0] res2 = 'x;
    logic stall_hold = 1'bx;
`ifdef MULDIV_EARLY_OUT_EN
    int exl2 = 4;
`else
    int exl2 = 34;
`endif
    @(negedge clk);
    funct3 = F3_MUL; rs1_val = 32'h7; rs2_val = 32'hFFFF_FFFD; start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        lat1 = c; res1 = result;
        break;
      end
      start = 1'b0;
    end
    funct3 = F3_MULHU; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'h2; start = 1'b1;
    #1;
    stall_hold = stall;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        lat2 = c; res2 = result;
        break;
      end
      start = 1'b0;
    end
    start = 1'b0;
    tests_run++;
    if (lat1 !== 34 || res1 !== 32'hFFFF_FFEB) begin
      tests_failed++;
      $display("FAIL b2b_first: got %h lat %0d expected ffffffeb lat 34", res1, lat1);
    end
    tests_run++;
    if (stall_hold !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_stall_accept: got %b expected 1", stall_hold);
    end
    tests_run++;
    if (lat2 !== exl2 || res2 !== 32'h1) begin
      tests_failed++;
      $display("FAIL b2b_second: got %h lat %0d expected 00000001 lat %0d", res2, lat2, exl2);
    end
  endtask

  task automatic test_early_out;
`ifdef MULDIV_EARLY_OUT_EN
    int exl = 3;
`else
    int exl = 34;
`endif
    int lat;
    logic [31:0] res;
    run_op(F3_MUL, 32'd5, 32'd1, lat, res);
    tests_run++;
    if (lat !== exl || res !== 32'd5) begin
      tests_failed++;
      $display("FAIL early_mul_5x1: got %h lat %0d expected 00000005 lat %0d", res, lat, exl);
    end
    run_op(F3_MUL, 32'd9, 32'd0, lat, res);
    tests_run++;
    if (lat !== exl || res !== 32'd0) begin
      tests_failed++;
      $display("FAIL early_mul_x0: got %h lat %0d expected 00000000 lat %0d", res, lat, exl);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [31:0] res;
    bit seen_done = 1'b0;
    run_op(F3_DIVU, 32'd100, 32'd7, lat, res);
    tests_run++;
    if (res !== 32'd14 || lat !== 34) begin
      tests_failed++;
      $display("FAIL rst_setup: got %h lat %0d expected 0000000e lat 34", res, lat);
    end
    @(negedge clk);
    funct3 = F3_DIV; rs1_val = 32'd100; rs2_val = 32'd7; start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    tests_run++;
    if ({busy, done} !== 2'b00 || result !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid: got busy/done %b result %h expected 00 00000000",
               {busy, done}, result);
    end
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    tests_run++;
    if (seen_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_done: got %b expected 0", seen_done);
    end
    run_op(F3_REMU, 32'd100, 32'd7, lat, res);
    tests_run++;
    if (res !== 32'd2 || lat !== 34) begin
      tests_failed++;
      $display("FAIL rst_recover: got %h lat %0d expected 00000002 lat 34", res, lat);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'b000; rs1_val = 32'h0; rs2_val = 32'h0;
    test_reset;
    test_mul;
    test_mulh;
    test_div;
    test_special;
    test_flush;
    test_back_to_back;
    test_early_out;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
